fpu_add_arbiter: RTL and testbench
==================================

Name: fpu_add_arbiter

Overview:
- Shares the single non-pipelined FPU adder between NUM_REQ requesting controllers, e.g. add/sub/compare/accumulate controllers.
- Each requester presents an operand pair over an STB/BUSY handshake. The arbiter grants round-robin, drives the adder's input handshake, captures its result, and returns the sum to the owning requester.
- Exactly one operation is in flight at any time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width (IEEE-754 single).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_stb  in  NUM_REQ  requester i presents a valid operand pair
- req_busy  out  NUM_REQ  arbiter cannot accept from requester i
- req_a  in  NUM_REQ*DATA_W  operand A, slice i = [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand B, sliced as req_a
- rsp_stb  out  NUM_REQ  sum valid for requester i
- rsp_busy  in  NUM_REQ  requester i cannot take the result
- rsp_sum  out  DATA_W  result, shared by all requesters
- adder_a, adder_b  out  DATA_W  operands to the adder
- adder_input_STB  out  1  operands valid to the adder
- adder_BUSY  in  1  adder busy
- adder_sum  in  DATA_W  adder result
- adder_output_STB  in  1  adder result valid
- output_module_BUSY  out  1  arbiter busy toward the adder's output

Behaviour:
- Handshake rule, all interfaces: a transfer occurs on a rising clk edge where stb=1 and busy=0.
- Reset (rst=0), asynchronous:
  - state=IDLE, rr_ptr=NUM_REQ-1, owner=0.
  - Operand and result registers cleared to 0.
  - rsp_stb=0, adder_input_STB=0, output_module_BUSY=0, req_busy=all-ones.
- Reset mid-operation: the in-flight operation is abandoned with no response. Any later stray adder result is drained in IDLE.
- Arbitration: round-robin starting at rr_ptr+1 modulo NUM_REQ. The winner is the first i with req_stb[i]=1. Combinational from req_stb and rr_ptr.
- IDLE:
  - req_busy[i]=0 only for the winner, 1 for all others and when no request is present.
  - output_module_BUSY=0, so stray adder results are accepted and discarded.
  - On transfer: latch the winner's a/b into adder_a/adder_b, owner<=winner, go to ISSUE.
- ISSUE:
  - adder_input_STB=1, output_module_BUSY=1.
  - When adder_BUSY=0 the transfer occurs; go to WAIT_RESULT.
- WAIT_RESULT:
  - adder_input_STB=0, output_module_BUSY=0.
  - When adder_output_STB=1: rsp_sum<=adder_sum, go to DELIVER.
- DELIVER:
  - rsp_stb[owner]=1, all other rsp_stb=0, output_module_BUSY=1.
  - When rsp_busy[owner]=0 the transfer occurs: rr_ptr<=owner, go to IDLE.
- Outputs: req_busy, rsp_stb and adder_input_STB decode from state with no extra register stage. adder_a, adder_b and rsp_sum are registered.
- Latency: the request transfer, the ISSUE transfer and the DELIVER transfer each take one edge. Minimum request-to-response overhead is 3 cycles plus adder latency.
- Throughput: the next grant is possible in the cycle after DELIVER completes.
- Simultaneous requests: exactly one winner per IDLE cycle. Losers hold req_stb with stable operands until granted.
- A requester may deassert req_stb before it is granted without side effect.
- rsp_busy held high stalls the arbiter in DELIVER indefinitely; no timeout.
- Fairness: with all requesters permanently asserting, grants cycle 0,1,2,...,NUM_REQ-1,0,...

Optional Feature:
- Macro FPU_ARB_STATS_EN.
- Defined: adds two outputs.
  - op_count (16-bit): increments on every DELIVER transfer, saturates at 0xFFFF.
  - stall_count (16-bit): increments every cycle in IDLE where some req_stb is high and a different requester is being granted. As IDLE lasts one cycle per grant, this counts the losing requesters' waiting cycles. Saturating.
  - Both clear on reset.
- Undefined: neither port exists; behaviour otherwise identical.

Decomposition:
- Package fpu_arb_pkg:
  - state enum IDLE/ISSUE/WAIT_RESULT/DELIVER (2-bit).
  - FP_W=32.
  - Function for the index width of NUM_REQ.
- Sub-module rr_arbiter (NUM_REQ parameter): inputs req vector and rr_ptr; outputs one-hot grant, grant index and any_req. Purely combinational.

Test Plan:
- Single op: req0 a=0x3F800000 (1.0), b=0x40000000 (2.0) -> rsp_stb[0] with rsp_sum=0x40400000 (3.0). No other rsp_stb bit asserts.
- All four request together -> grants in order 0,1,2,3. The second round, all asserting again, also runs 0,1,2,3. Each requester receives its own sum.
- adder_BUSY held high for 5 cycles in ISSUE -> adder_input_STB stays 1 with stable operands; advances only on the cycle adder_BUSY falls.
- rsp_busy[owner] high for 10 cycles -> rsp_stb and rsp_sum held stable, no new grant. Then completion and rr_ptr=owner.
- rst pulsed low during WAIT_RESULT -> immediate IDLE with all outputs at reset values. A late adder_output_STB is drained in IDLE with no rsp_stb.
- With FPU_ARB_STATS_EN, run 3 ops -> op_count=3; contention case gives a nonzero stall_count.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and helpers for the FPU adder arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fpu_arb_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_RESULT = 2'd2,
    DELIVER     = 2'd3
  } arb_state_t;

  // Width of an index selecting one of n requesters; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first set request after i_rr_ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports:
//   i_req       request vector, one bit per requester
//   i_rr_ptr    index of the last served requester (search starts one past it)
//   o_grant     one-hot grant (all zero when no request)
//   o_grant_idx binary index of the granted requester
//   o_any_req   at least one request present
module rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any_req
);

  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    // Offset 1 first so the last served requester has the lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found         = 1'b1;
        o_grant[w_idx]  = 1'b1;
        o_grant_idx     = w_idx;
      end
    end
    o_any_req = w_found;
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one non-pipelined FPU adder among NUM_REQ requesters, round-robin, one op in flight.
// Latency: request->issue->(adder)->capture->deliver; 3 cycles plus adder latency minimum.
// Backpressure: STB/BUSY on every interface; adder_BUSY stalls ISSUE, rsp_busy stalls DELIVER.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   req_stb/busy/a/b     requester operand handshake, operands sliced i*DATA_W
//   rsp_stb/busy/sum     result handshake toward the owning requester; rsp_sum shared
//   adder_a/b/input_STB  operands and strobe to the adder, adder_BUSY back
//   adder_sum/output_STB adder result, accepted while output_module_BUSY is low
//   op_count/stall_count saturating statistics, present only with FPU_ARB_STATS_EN defined
module fpu_add_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = FP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_stb,
  output logic [NUM_REQ-1:0]        req_busy,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_stb,
  input  logic [NUM_REQ-1:0]        rsp_busy,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic [DATA_W-1:0]         adder_a,
  output logic [DATA_W-1:0]         adder_b,
  output logic                      adder_input_STB,
  input  logic                      adder_BUSY,
  input  logic [DATA_W-1:0]         adder_sum,
  input  logic                      adder_output_STB,
  output logic                      output_module_BUSY
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [15:0]               op_count,
  output logic [15:0]               stall_count
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [DATA_W-1:0] r_adder_a;
  logic [DATA_W-1:0] r_adder_b;
  logic [DATA_W-1:0] r_rsp_sum;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any_req;
  logic               w_req_xfer;
  logic               w_result_xfer;
  logic               w_deliver_xfer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req       (req_stb),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_req   (w_any_req)
  );

  always_comb begin
    w_state_nxt        = r_state;
    req_busy           = '1;
    rsp_stb            = '0;
    adder_input_STB    = 1'b0;
    output_module_BUSY = 1'b0;
    w_req_xfer         = 1'b0;
    w_result_xfer      = 1'b0;
    w_deliver_xfer     = 1'b0;
    case (r_state)
      IDLE: begin
        // Only the winner sees busy low, so a request transfer is exactly any_req.
        // output_module_BUSY stays low here so stray adder results are swallowed.
        if (w_any_req) begin
          req_busy    = ~w_grant;
          w_req_xfer  = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        adder_input_STB    = 1'b1;
        output_module_BUSY = 1'b1;
        if (!adder_BUSY) begin
          w_state_nxt = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (adder_output_STB) begin
          w_result_xfer = 1'b1;
          w_state_nxt   = DELIVER;
        end
      end
      DELIVER: begin
        rsp_stb[r_owner]   = 1'b1;
        output_module_BUSY = 1'b1;
        if (!rsp_busy[r_owner]) begin
          w_deliver_xfer = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= IDX_W'(NUM_REQ - 1);
      r_owner   <= '0;
      r_adder_a <= '0;
      r_adder_b <= '0;
      r_rsp_sum <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_xfer) begin
        r_adder_a <= req_a[w_grant_idx*DATA_W +: DATA_W];
        r_adder_b <= req_b[w_grant_idx*DATA_W +: DATA_W];
        r_owner   <= w_grant_idx;
      end
      if (w_result_xfer) begin
        r_rsp_sum <= adder_sum;
      end
      // Pointer moves only on completion, so the owner drops to lowest priority next.
      if (w_deliver_xfer) begin
        r_rr_ptr <= r_owner;
      end
    end
  end

  assign adder_a = r_adder_a;
  assign adder_b = r_adder_b;
  assign rsp_sum = r_rsp_sum;

`ifdef FPU_ARB_STATS_EN
  logic [15:0] r_op_count;
  logic [15:0] r_stall_count;
  logic        w_contention;

  // A loser is waiting whenever some request other than the granted one is high in IDLE.
  assign w_contention = (r_state == IDLE) && ((req_stb & ~w_grant) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_deliver_xfer && (r_op_count != 16'hFFFF)) begin
        r_op_count <= r_op_count + 16'd1;
      end
      if (w_contention && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign op_count    = r_op_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Self-checking bench for fpu_add_arbiter with a behavioural table-driven adder.
// Expected responses are queued at stimulus time and checked by a monitor process.
module tb_fpu_add_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_stb;
  logic [N-1:0]     req_busy;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     rsp_stb;
  logic [N-1:0]     rsp_busy;
  logic [W-1:0]     rsp_sum;
  logic [W-1:0]     adder_a;
  logic [W-1:0]     adder_b;
  logic             adder_input_STB;
  logic             adder_BUSY;
  logic [W-1:0]     adder_sum;
  logic             adder_output_STB;
  logic             output_module_BUSY;
`ifdef FPU_ARB_STATS_EN
  logic [15:0]      op_count;
  logic [15:0]      stall_count;
`endif

  always #5 clk = ~clk;

  fpu_add_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_stb            (req_stb),
    .req_busy           (req_busy),
    .req_a              (req_a),
    .req_b              (req_b),
    .rsp_stb            (rsp_stb),
    .rsp_busy           (rsp_busy),
    .rsp_sum            (rsp_sum),
    .adder_a            (adder_a),
    .adder_b            (adder_b),
    .adder_input_STB    (adder_input_STB),
    .adder_BUSY         (adder_BUSY),
    .adder_sum          (adder_sum),
    .adder_output_STB   (adder_output_STB),
    .output_module_BUSY (output_module_BUSY)
`ifdef FPU_ARB_STATS_EN
    ,
    .op_count           (op_count),
    .stall_count        (stall_count)
`endif
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } vec_t;

  // Hand-computed IEEE-754 single sums.
  localparam vec_t VEC [8] = '{
    '{32'h3F800000, 32'h40000000, 32'h40400000},  // 1.0 + 2.0 = 3.0
    '{32'h3FC00000, 32'h40200000, 32'h40800000},  // 1.5 + 2.5 = 4.0
    '{32'h3F000000, 32'h3E800000, 32'h3F400000},  // 0.5 + 0.25 = 0.75
    '{32'hBF800000, 32'h41000000, 32'h40E00000},  // -1.0 + 8.0 = 7.0
    '{32'h41200000, 32'h40C00000, 32'h41800000},  // 10.0 + 6.0 = 16.0
    '{32'h42C80000, 32'h41E00000, 32'h43000000},  // 100.0 + 28.0 = 128.0
    '{32'hC0000000, 32'hC0000000, 32'hC0800000},  // -2.0 + -2.0 = -4.0
    '{32'h3F800000, 32'h3F800000, 32'h40000000}   // 1.0 + 1.0 = 2.0
  };

  typedef struct {
    int          idx;
    logic [31:0] sum;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks    = 0;
  int   failures  = 0;
  int   adder_lat = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    for (int k = 0; k < 8; k++) begin
      v = VEC[k];
      if (v.a == a && v.b == b) return v.s;
    end
    return 32'hDEADBEEF;
  endfunction

  // One clock: note grants seen before the edge, then drop those requests after it.
  task automatic tick();
    logic [N-1:0] g;
    @(negedge clk);
    g = req_stb & ~req_busy;
    for (int i = 0; i < N; i++) if (g[i]) grant_log.push_back(i);
    @(posedge clk);
    #1;
    req_stb = req_stb & ~g;
  endtask

  task automatic post(input int i, input int k, input bit expect_rsp);
    vec_t v;
    exp_t e;
    v = VEC[k];
    req_a[i*W +: W] = v.a;
    req_b[i*W +: W] = v.b;
    req_stb[i]      = 1'b1;
    if (expect_rsp) begin
      e.idx = i;
      e.sum = v.s;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 300 && sb.size() != 0; n++) tick();
    chk({name, "_drain_left"}, 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  task automatic expect_grants(input string name, input int n, input int e[4]);
    int sz;
    sz = grant_log.size();
    chk({name, "_grant_cnt"}, 64'(sz), 64'(n));
    for (int j = 0; j < n; j++) begin
      chk({name, "_grant"}, 64'((j < sz) ? grant_log[j] : -1), 64'(e[j]));
    end
    grant_log.delete();
  endtask

  task automatic monitor();
    exp_t         e;
    logic [N-1:0] x;
    logic [N-1:0] ev;
    forever begin
      @(negedge clk);
      x = rsp_stb & ~rsp_busy;
      if (rst && x != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_stb), 64'(0));
        end else begin
          e  = sb.pop_front();
          ev = N'(1) << e.idx;
          chk("rsp_owner", 64'(rsp_stb), 64'(ev));
          chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
        end
      end
    end
  endtask

  // Non-pipelined adder: accepts operands, answers after adder_lat cycles,
  // holds its result strobe until the arbiter accepts it.
  task automatic adder_model();
    logic        in_x;
    logic        out_x;
    logic [31:0] ca;
    logic [31:0] cb;
    logic        pend;
    int          cd;
    logic [31:0] ps;
    pend = 1'b0;
    cd   = 0;
    ps   = '0;
    forever begin
      @(negedge clk);
      in_x  = adder_input_STB && !adder_BUSY;
      ca    = adder_a;
      cb    = adder_b;
      out_x = adder_output_STB && !output_module_BUSY;
      @(posedge clk);
      #1;
      if (out_x) adder_output_STB = 1'b0;
      if (in_x) begin
        pend = 1'b1;
        cd   = adder_lat;
        ps   = lookup(ca, cb);
      end
      if (pend && !adder_output_STB) begin
        if (cd <= 1) begin
          adder_output_STB = 1'b1;
          adder_sum        = ps;
          pend             = 1'b0;
        end else begin
          cd--;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   eo[4];
    vec_t v;
    rst              = 1'b0;
    req_stb          = '0;
    req_a            = '0;
    req_b            = '0;
    rsp_busy         = '0;
    adder_BUSY       = 1'b0;
    adder_output_STB = 1'b0;
    adder_sum        = '0;
    fork
      monitor();
      adder_model();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_busy", 64'(req_busy), 64'(4'b1111));
    chk("rst_rsp_stb", 64'(rsp_stb), 64'(0));
    chk("rst_in_stb", 64'(adder_input_STB), 64'(0));
    chk("rst_omb", 64'(output_module_BUSY), 64'(0));
    chk("rst_ops", {adder_a, adder_b}, 64'(0));
    chk("rst_sum", 64'(rsp_sum), 64'(0));
    rst = 1'b1;
    tick();

    // All four at once, two rounds
    for (int i = 0; i < 4; i++) post(i, i, 1'b1);
    drain("round1");
    eo = '{0, 1, 2, 3};
    expect_grants("round1", 4, eo);
    for (int i = 0; i < 4; i++) post(i, i + 4, 1'b1);
    drain("round2");
    expect_grants("round2", 4, eo);

    // Single op 1.0 + 2.0
    post(0, 0, 1'b1);
    drain("single");
    eo = '{0, 0, 0, 0};
    expect_grants("single", 1, eo);

    // Adder busy stall in ISSUE
    v = VEC[5];
    adder_BUSY = 1'b1;
    post(2, 5, 1'b1);
    tick();
    chk("issue_omb", 64'(output_module_BUSY), 64'(1));
    for (int c = 0; c < 5; c++) begin
      chk("issue_stb_held", 64'(adder_input_STB), 64'(1));
      chk("issue_ops_stable", {adder_a, adder_b}, {v.a, v.b});
      tick();
    end
    adder_BUSY = 1'b0;
    chk("issue_stb_before_drop", 64'(adder_input_STB), 64'(1));
    tick();
    chk("issue_done", 64'(adder_input_STB), 64'(0));
    drain("adder_busy");
    eo = '{2, 0, 0, 0};
    expect_grants("adder_busy", 1, eo);

    // Response stall: owner 1 held busy, requesters 2 and 0 waiting
    v = VEC[6];
    rsp_busy[1] = 1'b1;
    post(1, 6, 1'b1);
    for (int n = 0; n < 30 && !rsp_stb[1]; n++) tick();
    chk("stall_reached", 64'(rsp_stb[1]), 64'(1));
    post(2, 7, 1'b1);
    post(0, 0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_rsp_stb", 64'(rsp_stb), 64'(4'b0010));
      chk("stall_sum", 64'(rsp_sum), 64'(v.s));
      chk("stall_no_grant", 64'(req_busy), 64'(4'b1111));
    end
    rsp_busy[1] = 1'b0;
    drain("rsp_busy");
    eo = '{1, 2, 0, 0};
    expect_grants("rsp_busy", 3, eo);

    // Reset during WAIT_RESULT; the late adder result must be drained silently
    adder_lat = 6;
    post(3, 1, 1'b0);
    tick();
    tick();
    chk("in_wait", {62'b0, adder_input_STB, output_module_BUSY}, 64'(0));
    rst = 1'b0;
    #1;
    chk("mid_rst_req_busy", 64'(req_busy), 64'(4'b1111));
    chk("mid_rst_rsp_stb", 64'(rsp_stb), 64'(0));
    chk("mid_rst_in_stb", 64'(adder_input_STB), 64'(0));
    chk("mid_rst_omb", 64'(output_module_BUSY), 64'(0));
    chk("mid_rst_ops", {adder_a, adder_b}, 64'(0));
    chk("mid_rst_sum", 64'(rsp_sum), 64'(0));
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("stray_drained", 64'(adder_output_STB), 64'(0));
    chk("stray_no_rsp", 64'(rsp_stb), 64'(0));
    adder_lat = 1;
    grant_log.delete();

    // Recovery, then a two-way contention
    post(2, 3, 1'b1);
    drain("recover");
    post(0, 4, 1'b1);
    post(1, 5, 1'b1);
    drain("contend");
    eo = '{2, 0, 1, 0};
    expect_grants("post_reset", 3, eo);
`ifdef FPU_ARB_STATS_EN
    chk("op_count", 64'(op_count), 64'(3));
    chk("stall_count", 64'(stall_count), 64'(1));
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
